// File: rtl/loom_dpi_caller.sv
// Bridges a DUT-side trigger to a DPI register-file call/return handshake, freezing the DUT while in flight.
// Optional return-wait timeout enabled by defining LOOM_DPI_CALLER_TIMEOUT_EN.
module loom_dpi_caller #(
    parameter int MAX_ARGS  = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     trig_i,
    input  logic [MAX_ARGS*32-1:0]   trig_args_i,
    output logic                     stall_o,
    output logic                     done_o,
    output logic [63:0]              result_o,
    output logic [MAX_ARGS*32-1:0]   out_args_o,
    output logic [31:0]              call_cnt_o,
    input  logic [TIMEOUT_W-1:0]     timeout_cycles_i,
    output logic                     timeout_o,
    output logic                     dpi_call_valid_o,
    input  logic                     dpi_call_ready_i,
    output logic [MAX_ARGS*32-1:0]   dpi_call_args_o,
    input  logic                     dpi_ret_valid_i,
    output logic                     dpi_ret_ready_o,
    input  logic [64+MAX_ARGS*32-1:0] dpi_ret_data_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALL = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [63:0] result_reg;
    logic [31:0] call_cnt_reg;
    logic        trig_accept, call_fire, ret_fire;

    assign trig_accept = (state_reg == IDLE) && trig_i;
    assign call_fire   = (state_reg == CALL) && dpi_call_ready_i;
    assign ret_fire    = (state_reg == WAIT) && dpi_ret_valid_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trig_i) state_next = CALL;
            CALL:    if (dpi_call_ready_i) state_next = WAIT;
            WAIT:    if (dpi_ret_valid_i) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            result_reg   <= '0;
            call_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ret_fire) begin
                result_reg   <= dpi_ret_data_i[63:0];
                call_cnt_reg <= call_cnt_reg + 32'd1;
            end
        end
    end

    // One register pair per argument word: outgoing call args and host write-back.
    for (genvar gi = 0; gi < MAX_ARGS; gi++) begin : g_word
        logic [31:0] arg_word_reg;
        logic [31:0] out_word_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                arg_word_reg <= '0;
                out_word_reg <= '0;
            end else begin
                if (trig_accept) arg_word_reg <= trig_args_i[gi*32 +: 32];
                if (ret_fire)    out_word_reg <= dpi_ret_data_i[64 + gi*32 +: 32];
            end
        end

        assign dpi_call_args_o[gi*32 +: 32] = arg_word_reg;
        assign out_args_o[gi*32 +: 32]      = out_word_reg;
    end

`ifdef LOOM_DPI_CALLER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic                 timeout_reg;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (call_fire)
            wait_cnt_next = '0;
        else if ((state_reg == WAIT) && (wait_cnt_reg != '1))
            wait_cnt_next = wait_cnt_reg + TIMEOUT_W'(1);
    end

    // Flag only; the call keeps waiting for the host after a timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (trig_accept)
                timeout_reg <= 1'b0;
            else if ((state_reg == WAIT) && (timeout_cycles_i != '0) &&
                     (wait_cnt_next == timeout_cycles_i))
                timeout_reg <= 1'b1;
        end
    end

    assign timeout_o = timeout_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^timeout_cycles_i ^ call_fire;
    assign timeout_o = 1'b0;
`endif

    assign result_o         = result_reg;
    assign call_cnt_o       = call_cnt_reg;
    assign dpi_call_valid_o = (state_reg == CALL);
    assign dpi_ret_ready_o  = (state_reg == WAIT);
    assign done_o           = (state_reg == RESP);
    assign stall_o          = (state_reg == CALL) || (state_reg == WAIT) ||
                              ((state_reg == IDLE) && trig_i);

endmodule

// File: tb/tb_loom_dpi_caller.sv
// Scoreboard bench for loom_dpi_caller: stimulus pushes expected returns, a monitor checks each done_o.
module tb_loom_dpi_caller;
    localparam int MAX_ARGS  = 8;
    localparam int TIMEOUT_W = 16;
    localparam int AW        = MAX_ARGS * 32;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 trig_i = 1'b0;
    logic [AW-1:0]        trig_args_i = '0;
    logic                 stall_o, done_o, timeout_o;
    logic [63:0]          result_o;
    logic [AW-1:0]        out_args_o;
    logic [31:0]          call_cnt_o;
    logic [TIMEOUT_W-1:0] timeout_cycles_i = '0;
    logic                 dpi_call_valid_o;
    logic                 dpi_call_ready_i = 1'b0;
    logic [AW-1:0]        dpi_call_args_o;
    logic                 dpi_ret_valid_i = 1'b0;
    logic                 dpi_ret_ready_o;
    logic [64+AW-1:0]     dpi_ret_data_i = '0;

    typedef struct packed {
        logic [63:0] result;
        logic [31:0] word1;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
`ifdef LOOM_DPI_CALLER_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    loom_dpi_caller #(.MAX_ARGS(MAX_ARGS), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .trig_i(trig_i), .trig_args_i(trig_args_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .out_args_o(out_args_o),
        .call_cnt_o(call_cnt_o), .timeout_cycles_i(timeout_cycles_i), .timeout_o(timeout_o),
        .dpi_call_valid_o(dpi_call_valid_o), .dpi_call_ready_i(dpi_call_ready_i),
        .dpi_call_args_o(dpi_call_args_o), .dpi_ret_valid_i(dpi_ret_valid_i),
        .dpi_ret_ready_o(dpi_ret_ready_o), .dpi_ret_data_i(dpi_ret_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic push_ret(input logic [63:0] res, input logic [31:0] w1, input logic [31:0] cnt);
        exp_t e;
        e.result = res; e.word1 = w1; e.cnt = cnt;
        exp_q.push_back(e);
        dpi_ret_data_i = '0;
        dpi_ret_data_i[63:0]   = res;
        dpi_ret_data_i[96 +: 32] = w1;
        dpi_ret_valid_i = 1'b1;
        $display("ret  result=0x%0h word1=0x%0h expect_cnt=%0d", res, w1, cnt);
    endtask

    // Monitor: every done_o pulse must match the oldest expected return.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_o", result_o, e.result);
                    check("out_args_w1", {32'd0, out_args_o[63:32]}, {32'd0, e.word1});
                    check("call_cnt_o", {32'd0, call_cnt_o}, {32'd0, e.cnt});
                    $display("done result=0x%0h cnt=%0d", result_o, call_cnt_o);
                end
            end
        end
    end

    initial begin
        // Reset state
        sample();
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_call_valid", {63'd0, dpi_call_valid_o}, 64'd0);
        check("rst_cnt", {32'd0, call_cnt_o}, 64'd0);
        step(); rst_ni = 1'b1; step();

        // Basic call: word0=0x11, ready immediately, return after 5 wait cycles
        dpi_call_ready_i = 1'b1;
        trig_i = 1'b1; trig_args_i = '0; trig_args_i[31:0] = 32'h11;
        sample();
        check("idle_trig_stall", {63'd0, stall_o}, 64'd1);
        step(); trig_i = 1'b0;
        sample();
        check("basic_call_valid", {63'd0, dpi_call_valid_o}, 64'd1);
        check("basic_call_arg0", {32'd0, dpi_call_args_o[31:0]}, 64'h11);
        step();
        sample();
        check("basic_valid_one_cycle", {63'd0, dpi_call_valid_o}, 64'd0);
        check("basic_ret_ready", {63'd0, dpi_ret_ready_o}, 64'd1);
        for (int i = 0; i < 4; i++) step();
        push_ret(64'hCAFE, 32'h0, 32'd1);
        step(); dpi_ret_valid_i = 1'b0;
        sample();
        check("resp_stall_low", {63'd0, stall_o}, 64'd0);
        step();
        sample();
        check("done_one_cycle", {63'd0, done_o}, 64'd0);

        // Backpressure: ready low for 4 cycles
        dpi_call_ready_i = 1'b0;
        trig_i = 1'b1; trig_args_i[31:0] = 32'h22; trig_args_i[63:32] = 32'h33;
        step(); trig_i = 1'b0; trig_args_i = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("bp_call_valid", {63'd0, dpi_call_valid_o}, 64'd1);
            check("bp_args", dpi_call_args_o[63:0], 64'h0000_0033_0000_0022);
            check("bp_stall", {63'd0, stall_o}, 64'd1);
            check("bp_no_ret_ready", {63'd0, dpi_ret_ready_o}, 64'd0);
            step();
        end
        dpi_call_ready_i = 1'b1;
        step();
        sample();
        check("bp_wait", {63'd0, dpi_ret_ready_o}, 64'd1);
        push_ret(64'h1234, 32'hA5A5_A5A5, 32'd2);
        step(); dpi_ret_valid_i = 1'b0; dpi_ret_data_i = '0;
        step();
        sample();
        check("out_args_hold", {32'd0, out_args_o[63:32]}, 64'hA5A5_A5A5);
        check("result_hold", result_o, 64'h1234);

        // trig held high through WAIT: one call, next only after RESP->IDLE
        trig_i = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            sample();
            check("hold_no_recall", {63'd0, dpi_call_valid_o}, 64'd0);
            step();
        end
        push_ret(64'h55, 32'h0, 32'd3);
        step(); dpi_ret_valid_i = 1'b0;
        step();
        sample();
        check("hold_idle_stall", {63'd0, stall_o}, 64'd1);
        step(); trig_i = 1'b0;
        sample();
        check("hold_second_call", {63'd0, dpi_call_valid_o}, 64'd1);
        step();
        push_ret(64'h66, 32'h0, 32'd4);
        step(); dpi_ret_valid_i = 1'b0;
        step();

        // Timeout: limit 3, no return for a while
        timeout_cycles_i = 16'd3;
        trig_i = 1'b1;
        step(); trig_i = 1'b0;
        step();
        sample();
        check("to_clear_entry", {63'd0, timeout_o}, 64'd0);
        step(); step();
        sample();
        check("to_before_limit", {63'd0, timeout_o}, 64'd0);
        step();
        sample();
        check("to_flag", {63'd0, timeout_o}, {63'd0, TO_EXP});
        check("to_stall", {63'd0, stall_o}, 64'd1);
        step(); step();
        push_ret(64'h77, 32'h0, 32'd5);
        step(); dpi_ret_valid_i = 1'b0;
        sample();
        check("to_sticky", {63'd0, timeout_o}, {63'd0, TO_EXP});
        step();

        // Reset mid-WAIT; new trig clears timeout first
        trig_i = 1'b1; trig_args_i[31:0] = 32'h99;
        step(); trig_i = 1'b0; trig_args_i = '0;
        sample();
        check("trig_clears_to", {63'd0, timeout_o}, 64'd0);
        step(); step();
        rst_ni = 1'b0;
        step(); step();
        sample();
        check("rst_result", result_o, 64'd0);
        check("rst_out_args", out_args_o[63:0], 64'd0);
        check("rst_call_args", dpi_call_args_o[63:0], 64'd0);
        check("rst_flags", {58'd0, dpi_call_valid_o, dpi_ret_ready_o, done_o, timeout_o, stall_o,
                            call_cnt_o != 32'd0}, 64'd0);
        rst_ni = 1'b1;
        dpi_ret_valid_i = 1'b1; dpi_ret_data_i = '0; dpi_ret_data_i[63:0] = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            check("stale_ret_ignored", {62'd0, done_o, dpi_ret_ready_o}, 64'd0);
        end
        dpi_ret_valid_i = 1'b0;
        sample();
        check("stale_cnt", {32'd0, call_cnt_o}, 64'd0);

        // Fresh call after reset counts from 1
        timeout_cycles_i = '0;
        trig_i = 1'b1;
        step(); trig_i = 1'b0;
        step();
        push_ret(64'hBEEF, 32'h0, 32'd1);
        step(); dpi_ret_valid_i = 1'b0;
        step(); step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/loom_dpi_caller.md
LOOM_DPI_CALLER -- requirements
Module: loom_dpi_caller

Interface
REQ-001 SHALL have parameter MAX_ARGS, default 8, number of 32-bit argument words.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, width of the return-wait cycle counter.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trig_i  input  1  DUT requests a DPI call.
REQ-006 SHALL have port trig_args_i  input  MAX_ARGS*32  call arguments, word k at bits [32k+31:32k].
REQ-007 SHALL have port stall_o  output  1  freeze DUT while a call is in flight.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port result_o  output  64  captured scalar return value.
REQ-010 SHALL have port out_args_o  output  MAX_ARGS*32  captured host-written argument words.
REQ-011 SHALL have port call_cnt_o  output  32  completed-call counter.
REQ-012 SHALL have port timeout_cycles_i  input  TIMEOUT_W  return-wait limit; 0 = disabled.
REQ-013 SHALL have port timeout_o  output  1  sticky return-wait timeout flag.
REQ-014 SHALL have port dpi_call_valid_o  output  1  call request to the register file.
REQ-015 SHALL have port dpi_call_ready_i  input  1  register file accepts the call.
REQ-016 SHALL have port dpi_call_args_o  output  MAX_ARGS*32  arguments presented with the call.
REQ-017 SHALL have port dpi_ret_valid_i  input  1  host result available.
REQ-018 SHALL have port dpi_ret_ready_o  output  1  caller accepts the result.
REQ-019 SHALL have port dpi_ret_data_i  input  64+MAX_ARGS*32  scalar result in [63:0], argument words in [64+:MAX_ARGS*32].

Function
REQ-020 SHALL implement FSM states IDLE, CALL, WAIT, RESP; reset state IDLE.
REQ-021 SHALL, in IDLE with trig_i=1, latch trig_args_i into an argument register, clear timeout_o, and move to CALL next cycle.
REQ-022 SHALL ignore trig_i in CALL, WAIT and RESP, with no queuing.
REQ-023 SHALL drive dpi_call_valid_o=1 exactly while in CALL, and dpi_call_args_o from the argument register, held stable until handshake.
REQ-024 SHALL, on dpi_call_valid_o && dpi_call_ready_i, move CALL->WAIT and clear the wait counter.
REQ-025 SHALL drive dpi_ret_ready_o=1 exactly while in WAIT.
REQ-026 SHALL, on dpi_ret_valid_i && dpi_ret_ready_o, capture dpi_ret_data_i[63:0] into result_o and the upper bits into out_args_o, and move WAIT->RESP.
REQ-027 SHALL ignore dpi_ret_valid_i outside WAIT.
REQ-028 SHALL assert done_o=1 only in RESP, increment call_cnt_o by 1 on RESP entry (wrapping 0xFFFFFFFF->0), and move RESP->IDLE unconditionally.
REQ-029 SHALL make stall_o combinational: 1 in CALL or WAIT, or in IDLE when trig_i=1; 0 in RESP and otherwise.
REQ-030 SHALL hold result_o and out_args_o until the next return capture.
REQ-031 SHALL keep minimum latency trig accepted at cycle N -> call_valid at N+1 -> (ready at N+1) WAIT at N+2 -> (ret_valid at N+2) done_o at N+3.

Reset
REQ-032 SHALL, while rst_ni=0, force state IDLE and all outputs to 0: dpi_call_valid_o, dpi_ret_ready_o, done_o, timeout_o, result_o, out_args_o, call_cnt_o, and dpi_call_args_o (argument register cleared).
REQ-033 SHALL, on reset mid-call, abandon the in-flight call; a later dpi_ret_valid_i SHALL be ignored until a new call reaches WAIT.

Configuration
REQ-034 SHALL, with LOOM_DPI_CALLER_TIMEOUT_EN defined, count cycles spent in WAIT, saturating at all-ones.
REQ-035 SHALL, with LOOM_DPI_CALLER_TIMEOUT_EN defined and timeout_cycles_i!=0, set timeout_o when the count equals timeout_cycles_i, remaining in WAIT; timeout_o stays set until the next accepted trig_i or reset.
REQ-036 SHALL, without LOOM_DPI_CALLER_TIMEOUT_EN, omit the counter, tie timeout_o to 0, and ignore timeout_cycles_i.

Verification
REQ-037 SHALL cover basic call: trig_i pulse with args word0=0x11, ready=1 immediately, ret_valid after 5 cycles with data[63:0]=0xCAFE -> call_valid 1 cycle, done_o 1 cycle, result_o=0xCAFE, call_cnt_o=1.
REQ-038 SHALL cover backpressure: call_ready=0 for 4 cycles -> call_valid and args stable throughout, stall_o=1, no state advance.
REQ-039 SHALL cover trig ignored: trig_i held high through WAIT -> exactly one call; a new call only after RESP->IDLE.
REQ-040 SHALL cover timeout (macro on): timeout_cycles_i=3, no ret_valid -> timeout_o=1 after the 3rd WAIT cycle, stall_o still 1; a later ret_valid -> done_o.
REQ-041 SHALL cover reset mid-WAIT: rst_ni low 2 cycles -> all outputs 0, IDLE; a stale ret_valid is ignored and call_cnt_o stays 0.
REQ-042 SHALL cover out_args: ret data word1=0xA5A5A5A5 -> out_args_o[63:32]=0xA5A5A5A5 after done_o.
